// File: rtl/dsp_aw_channel.sv
// dsp_aw_channel
//   Write-address (AW) dispatcher. A single holding register accepts one AW
//   transaction from the master, decodes its slave ID from an AWADDR bit
//   field and presents it to exactly one slave lane. When the slave accepts,
//   a one-cycle push strobe tells the W and B dispatchers which slave owns
//   the burst. A new master transaction may load in the same cycle the held
//   one is issued, giving one issue per cycle when slaves are always ready.
//
//   Optional build macro: DSP_AW_OUTSTANDING_LIMIT_EN
//     Defined   : an outstanding counter (issued minus completed B responses)
//                 throttles m_AWREADY_o at OUTSTANDING_AMT.
//     Undefined : no counter; dsp_B_done_i is unused.
//
// Ports
//   ACLK_i, ARESET_i         clock, synchronous active-high reset
//   m_AW*_i, m_AWVALID_i     master AW request
//   m_AWREADY_o              master AW ready
//   sa_AW*_o                 AW fields broadcast to all slave lanes
//                            (slave k at [W*(k+1)-1 -: W])
//   sa_AWVALID_o             one-hot valid for the selected slave lane
//   sa_AWREADY_i             per-slave ready
//   dsp_AW_slv_id_o          slave ID of the held/last-issued transaction
//   dsp_AW_shift_en_o        1-cycle strobe on each slave-side handshake
//   dsp_B_done_i             1-cycle strobe on each master B handshake
module dsp_aw_channel #(
  parameter int SLV_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int SLV_ID_W          = $clog2(SLV_AMT),
  parameter int SLV_ID_MSB_IDX    = 30,
  parameter int SLV_ID_LSB_IDX    = 30
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESET_i,
  input  logic [TRANS_MST_ID_W-1:0]              m_AWID_i,
  input  logic [ADDR_WIDTH-1:0]                  m_AWADDR_i,
  input  logic [TRANS_BURST_W-1:0]               m_AWBURST_i,
  input  logic [TRANS_DATA_LEN_W-1:0]            m_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W-1:0]           m_AWSIZE_i,
  input  logic                                   m_AWVALID_i,
  output logic                                   m_AWREADY_o,
  output logic [TRANS_MST_ID_W*SLV_AMT-1:0]      sa_AWID_o,
  output logic [ADDR_WIDTH*SLV_AMT-1:0]          sa_AWADDR_o,
  output logic [TRANS_BURST_W*SLV_AMT-1:0]       sa_AWBURST_o,
  output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]    sa_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]   sa_AWSIZE_o,
  output logic [SLV_AMT-1:0]                     sa_AWVALID_o,
  input  logic [SLV_AMT-1:0]                     sa_AWREADY_i,
  output logic [SLV_ID_W-1:0]                    dsp_AW_slv_id_o,
  output logic                                   dsp_AW_shift_en_o,
  input  logic                                   dsp_B_done_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [TRANS_MST_ID_W-1:0]    awid_q;
  logic [ADDR_WIDTH-1:0]        awaddr_q;
  logic [TRANS_BURST_W-1:0]     awburst_q;
  logic [TRANS_DATA_LEN_W-1:0]  awlen_q;
  logic [TRANS_DATA_SIZE_W-1:0] awsize_q;
  logic [SLV_ID_W-1:0]          slv_id_q;

  logic               held;
  logic [SLV_AMT-1:0] lane_valid;
  logic               sa_hs;
  logic               m_hs;
  logic               room;

  // Lane select: an ID with no matching lane leaves every VALID low, so the
  // transaction simply stalls in the holding register.
  always_comb begin
    held       = (state_q == BUSY);
    lane_valid = '0;
    for (int unsigned k = 0; k < SLV_AMT; k++) begin
      lane_valid[k] = held && (slv_id_q == SLV_ID_W'(k));
    end
    sa_hs = |(lane_valid & sa_AWREADY_i);
    m_hs  = m_AWVALID_i & m_AWREADY_o;
  end

`ifdef DSP_AW_OUTSTANDING_LIMIT_EN
  localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Issue and completion in the same cycle cancel; completion at zero is
  // ignored so the counter cannot wrap.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      cnt_q <= '0;
    end else if (sa_hs && !dsp_B_done_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!sa_hs && dsp_B_done_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // The held transaction counts against the limit before it is issued.
  always_comb begin
    room = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, held}) < (CNT_W + 1)'(OUTSTANDING_AMT);
  end
`else
  logic unused_b_done;

  always_comb begin
    room          = 1'b1;
    unused_b_done = dsp_B_done_i;
  end
`endif

  // State register
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a master handshake while BUSY always coincides with sa_hs,
  // so the register reloads and stays BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_hs) state_d = BUSY;
      BUSY:    if (sa_hs && !m_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Holding register
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      awid_q    <= '0;
      awaddr_q  <= '0;
      awburst_q <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      slv_id_q  <= '0;
    end else if (m_hs) begin
      awid_q    <= m_AWID_i;
      awaddr_q  <= m_AWADDR_i;
      awburst_q <= m_AWBURST_i;
      awlen_q   <= m_AWLEN_i;
      awsize_q  <= m_AWSIZE_i;
      slv_id_q  <= SLV_ID_W'(m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX]);
    end
  end

  // Outputs. The push strobe is masked during reset so a transaction
  // dropped by reset never reaches the W/B dispatchers.
  always_comb begin
    m_AWREADY_o       = (~held | sa_hs) & room;
    sa_AWVALID_o      = lane_valid;
    dsp_AW_shift_en_o = sa_hs & ~ARESET_i;
    dsp_AW_slv_id_o   = slv_id_q;
    sa_AWID_o         = {SLV_AMT{awid_q}};
    sa_AWADDR_o       = {SLV_AMT{awaddr_q}};
    sa_AWBURST_o      = {SLV_AMT{awburst_q}};
    sa_AWLEN_o        = {SLV_AMT{awlen_q}};
    sa_AWSIZE_o       = {SLV_AMT{awsize_q}};
  end

endmodule

// File: doc/dsp_aw_channel.md
DSP_AW_CHANNEL -- requirements
Module: dsp_aw_channel

Interface
REQ-001 SHALL have parameter SLV_AMT, default 2, number of slave ports.
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8, maximum accepted AW transactions without a completed write response.
REQ-003 SHALL have parameters ADDR_WIDTH 32, TRANS_MST_ID_W 5, TRANS_BURST_W 2, TRANS_DATA_LEN_W 3, TRANS_DATA_SIZE_W 3, each giving the AW field width.
REQ-004 SHALL have parameters SLV_ID_W = $clog2(SLV_AMT), SLV_ID_MSB_IDX 30 and SLV_ID_LSB_IDX 30, giving the slave-select bit field of AWADDR.
REQ-005 SHALL have ports: ACLK_i in 1 clock; ARESET_i in 1 reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have master AW ports: m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i and m_AWSIZE_i, all inputs at parameter width; m_AWVALID_i in 1; m_AWREADY_o out 1.
REQ-007 SHALL have slave AW ports: sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o and sa_AWSIZE_o, all outputs of field width times SLV_AMT, packed with slave k at [W*(k+1)-1 -: W]; sa_AWVALID_o out SLV_AMT; sa_AWREADY_i in SLV_AMT.
REQ-008 SHALL have dsp_AW_slv_id_o out SLV_ID_W, the slave ID of the issued transaction, and dsp_AW_shift_en_o out 1, a 1-cycle push strobe to the W and B dispatchers.
REQ-009 SHALL have dsp_B_done_i in 1, a 1-cycle strobe on each master B handshake.

Function
REQ-010 SHALL hold one transaction in a single holding register with valid flag held; states are IDLE (held=0) and BUSY (held=1).
REQ-011 SHALL drive m_AWREADY_o = (~held | sa_hs) & (cnt + held < OUTSTANDING_AMT), using registered cnt and held only.
- sa_hs is the slave-side handshake defined in REQ-013.
REQ-012 SHALL, on a master handshake (m_AWVALID_i & m_AWREADY_o), latch all AW fields and slv_id = m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX], and set held.
- Latency is 1 cycle: the handshake occurs at edge N and sa_AWVALID_o is high from N+1.
REQ-013 SHALL assert only sa_AWVALID_o[slv_id] while held; sa_hs = held & sa_AWREADY_i[slv_id].
REQ-014 SHALL broadcast the latched fields on every slave lane; the fields are don't-care where the lane's VALID is low.
REQ-015 SHALL hold the latched fields and VALID stable until sa_hs, with no retraction.
REQ-016 SHALL drive dsp_AW_shift_en_o = sa_hs combinationally and dsp_AW_slv_id_o = the latched slv_id.
REQ-017 SHALL handle simultaneous sa_hs and master handshake by loading the new transaction with held staying 1, allowing back-to-back issue of one transaction per cycle.
REQ-018 SHALL clear held on sa_hs without a master handshake.
REQ-019 SHALL keep outstanding counter cnt of width $clog2(OUTSTANDING_AMT+1): +1 on sa_hs, -1 on dsp_B_done_i, unchanged when both occur.
REQ-020 SHALL ignore dsp_B_done_i when cnt==0 (no underflow).
- Increment never exceeds OUTSTANDING_AMT, by REQ-011.
REQ-021 SHALL accept a slv_id >= SLV_AMT unchanged and assert no sa_AWVALID_o bit for it; such a transaction stalls until reset.

Reset
REQ-022 SHALL, at a clock edge with ARESET_i=1, clear held and cnt, regardless of any handshake in that cycle.
REQ-023 SHALL give the following post-reset output values: m_AWREADY_o=1, sa_AWVALID_o=0, dsp_AW_shift_en_o=0, dsp_AW_slv_id_o=0, latched fields=0.
REQ-024 SHALL, on reset asserted while BUSY, drop the held transaction with no shift_en pulse.

Configuration
REQ-025 SHALL, with macro DSP_AW_OUTSTANDING_LIMIT_EN defined, implement cnt and the limit term of REQ-011.
REQ-026 SHALL, without DSP_AW_OUTSTANDING_LIMIT_EN, omit cnt, giving m_AWREADY_o = ~held | sa_hs, and leave dsp_B_done_i unused.

Verification
REQ-027 SHALL cover: after reset, AWADDR=0x4000_0000, AWID=3, slave 1 ready -> sa_AWVALID_o=2'b10 at N+1, shift_en pulse, slv_id_o=1, sa_AWID_o[9:5]=3.
REQ-028 SHALL cover: streaming 4 AWs alternating slave 0/1, both slaves always ready -> one issue per cycle, 4 shift_en pulses in order 0,1,0,1.
REQ-029 SHALL cover: sa_AWREADY_i[0]=0 for 5 cycles while BUSY on slave 0 -> fields stable, m_AWREADY_o=0, no shift_en until ready rises.
REQ-030 SHALL cover, with the macro, OUTSTANDING_AMT=8: 8 issued with no dsp_B_done_i -> m_AWREADY_o=0; one dsp_B_done_i -> ready next cycle; simultaneous sa_hs and done -> cnt unchanged.
REQ-031 SHALL cover: ARESET_i high while BUSY with sa_AWREADY_i high -> no shift_en, sa_AWVALID_o=0 and cnt=0 next cycle.
REQ-032 SHALL cover: dsp_B_done_i at cnt=0 -> cnt stays 0.
